// File: rtl/onc_16_dmem_mmio.sv
// Data-side memory for the ONC-16 CPU: word RAM plus an I/O page holding GPIO, cycle counter and compare timer.
// Optional timer block is built only when ONC16_MMIO_TIMER_EN is defined.
module onc_16_dmem_mmio #(
  parameter int                 DATA_W    = 16,
  parameter int                 RAM_DEPTH = 256,
  parameter logic [DATA_W-1:0]  IO_BASE   = 16'hFF00,
  parameter int                 GPIO_W    = 8
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_dout,
  input  logic              dmem_we,
  output logic [DATA_W-1:0] dmem_din,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              irq
);

  localparam int            RAM_AW  = $clog2(RAM_DEPTH);
  localparam logic [DATA_W:0] IO_LAST = {1'b0, IO_BASE} + (DATA_W+1)'(255);

  logic [DATA_W-1:0] r_ram [RAM_DEPTH];
  logic [GPIO_W-1:0] r_gpio_out;
  logic [GPIO_W-1:0] r_sync_p0;
  logic [GPIO_W-1:0] r_sync_p1;
  logic [DATA_W-1:0] r_cycle;

  logic              w_we;
  logic              w_is_ram;
  logic              w_is_io;
  logic [7:0]        w_off;
  logic              w_io_wr;
  logic              w_wr_gpio;
  logic [DATA_W-1:0] w_rd;

  assign w_we      = en & dmem_we;
  assign w_is_ram  = (dmem_addr < IO_BASE);
  assign w_is_io   = !w_is_ram && ({1'b0, dmem_addr} <= IO_LAST);
  // Page offset only needs the low byte: the page is exactly 256 words long.
  assign w_off     = dmem_addr[7:0] - IO_BASE[7:0];
  assign w_io_wr   = w_we & w_is_io;
  assign w_wr_gpio = w_io_wr && (w_off == 8'd0);

  always_ff @(posedge clock) begin
    if (w_we && w_is_ram)
      r_ram[dmem_addr[RAM_AW-1:0]] <= dmem_dout;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_gpio_out <= '0;
      r_sync_p0  <= '0;
      r_sync_p1  <= '0;
      r_cycle    <= '0;
    end else begin
      if (w_wr_gpio)
        r_gpio_out <= dmem_dout[GPIO_W-1:0];
      // synchronizer stage p0 -> p1
      r_sync_p0 <= gpio_in;
      r_sync_p1 <= r_sync_p0;
      r_cycle   <= r_cycle + 1'b1;
    end
  end

`ifdef ONC16_MMIO_TIMER_EN
  logic [DATA_W-1:0] r_tcnt;
  logic [DATA_W-1:0] r_tcmp;
  logic [2:0]        r_tctrl;
  logic              r_flag;
  logic              w_match;
  logic              w_wr_cnt;
  logic              w_wr_cmp;
  logic              w_wr_ctrl;

  assign w_match   = r_tctrl[0] && (r_tcnt == r_tcmp);
  assign w_wr_cnt  = w_io_wr && (w_off == 8'd2);
  assign w_wr_cmp  = w_io_wr && (w_off == 8'd3);
  assign w_wr_ctrl = w_io_wr && (w_off == 8'd4);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_tcnt  <= '0;
      r_tcmp  <= '1;
      r_tctrl <= '0;
      r_flag  <= 1'b0;
    end else begin
      // A CPU write to the count beats the run/reload path.
      if (w_wr_cnt)
        r_tcnt <= dmem_dout;
      else if (r_tctrl[0])
        r_tcnt <= (w_match && r_tctrl[1]) ? '0 : r_tcnt + 1'b1;
      if (w_wr_cmp)
        r_tcmp <= dmem_dout;
      if (w_wr_ctrl)
        r_tctrl <= dmem_dout[2:0];
      if (w_match)
        r_flag <= 1'b1;
      else if (w_wr_ctrl && dmem_dout[15])
        r_flag <= 1'b0;
    end
  end

  assign irq = r_flag & r_tctrl[2];
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    w_rd = '0;
    if (w_is_ram) begin
      w_rd = r_ram[dmem_addr[RAM_AW-1:0]];
    end else if (w_is_io) begin
      case (w_off)
        8'd0:    w_rd[GPIO_W-1:0] = r_gpio_out;
        8'd1:    w_rd[GPIO_W-1:0] = r_sync_p1;
`ifdef ONC16_MMIO_TIMER_EN
        8'd2:    w_rd = r_tcnt;
        8'd3:    w_rd = r_tcmp;
        8'd4:    begin
                   w_rd[2:0] = r_tctrl;
                   w_rd[15]  = r_flag;
                 end
`endif
        8'd5:    w_rd = r_cycle;
        default: w_rd = '0;
      endcase
    end
  end

  assign dmem_din = w_rd;
  assign gpio_out = r_gpio_out;

endmodule

// File: doc/onc_16_dmem_mmio.md
Name: onc_16_dmem_mmio

Overview:
- Data-side memory subsystem sitting directly downstream of the CPU top's dmem port.
- Consumes `dmem_addr`, `dmem_dout` and `dmem_we`; returns `dmem_din`.
- Contains word-addressed data RAM plus a memory-mapped I/O page: GPIO, cycle counter, compare timer.
- Read data is combinational, because the CPU writes back `dmem_din` in the same cycle it presents the address.

Parameters:
- DATA_W, 16, bus/word width.
- RAM_DEPTH, 256, data RAM words (power of two).
- IO_BASE, 16'hFF00, first address of the I/O page; the page spans IO_BASE..IO_BASE+255.
- GPIO_W, 8, GPIO input/output width.

Ports:
- clock  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  pipeline enable from the system; writes are committed only when en=1.
- dmem_addr  in  DATA_W  word address from the CPU.
- dmem_dout  in  DATA_W  write data from the CPU.
- dmem_we  in  1  write strobe; only 1'b1 counts as a write, X/0 means no write.
- dmem_din  out  DATA_W  read data to the CPU, combinational.
- gpio_in  in  GPIO_W  asynchronous external inputs.
- gpio_out  out  GPIO_W  GPIO output register.
- irq  out  1  timer interrupt request, level.

Behaviour:
- Address decode:
  - addr < IO_BASE → RAM at index addr mod RAM_DEPTH (aliasing intended).
  - IO_BASE ≤ addr ≤ IO_BASE+255 → I/O page.
  - addr > IO_BASE+255 → reads 0, writes ignored.
- Write commit: a write happens on the rising edge where `dmem_we==1 && en==1`. Read is combinational from the current addr and register state; a write and a read of the same location in one cycle returns the old value.
- RAM: not reset, contents undefined after power-up; rst leaves contents untouched.
- I/O map (offset from IO_BASE):
  - +0 GPIO_OUT, RW: low GPIO_W bits stored; reads zero-extended.
  - +1 GPIO_IN, RO: gpio_in via 2-flop synchronizer, 2-cycle latency; writes ignored.
  - +2 TIMER_CNT, RW.
  - +3 TIMER_CMP, RW.
  - +4 TIMER_CTRL:
    - bit0 run.
    - bit1 auto-reload.
    - bit2 irq_en.
    - bit15 match flag: read 1 when set; writing 1 clears it (W1C); writing 0 has no effect.
    - Other bits read 0.
  - +5 CYCLE_CNT, RO: free-running, +1 every clock, wraps 16'hFFFF→0; runs regardless of en.
  - Other offsets: read 0, write ignored.
- Timer, evaluated each edge:
  - run=0 → TIMER_CNT holds.
  - run=1 and CNT≠CMP → CNT+1, wrapping 16'hFFFF→0.
  - run=1 and CNT==CMP → flag set; CNT becomes 0 if auto-reload, else CNT+1.
- Timer simultaneous events:
  - A CPU write to TIMER_CNT overrides the increment/reload in that cycle.
  - A match in the same cycle as a flag W1C leaves the flag set (set wins).
- irq = flag & irq_en; registered-state derived, so it asserts the cycle after the match edge.
- Reset (asynchronous, any time including mid-transaction):
  - gpio_out=0, both synchronizer stages 0.
  - TIMER_CNT=0, TIMER_CMP=16'hFFFF, TIMER_CTRL=0 (flag=0), CYCLE_CNT=0, irq=0.
  - dmem_din follows decode of the current addr.

Optional Feature:
- Macro ONC16_MMIO_TIMER_EN.
- Defined: TIMER_CNT, TIMER_CMP, TIMER_CTRL and irq are implemented as described above.
- Undefined: offsets +2..+4 read 0 and ignore writes; irq tied to 0; no timer flops synthesized.
- GPIO, CYCLE_CNT and RAM are unaffected either way.

Test Plan:
- RAM write/read: write 16'h1234 to addr 16'h0010 with en=1 → next cycle addr 16'h0010 reads 16'h1234. The same write to addr 16'h0110 aliases: addr 16'h0010 reads the new value. A write with en=0 leaves the old value.
- GPIO: write 16'hABCD to IO_BASE → gpio_out=8'hCD, readback 16'h00CD. Drive gpio_in=8'h5A → IO_BASE+1 reads 16'h005A two clocks later, not before.
- Timer auto-reload: CMP=3, CTRL=16'h0007 → CNT 0,1,2,3,0,…; flag and irq go high the cycle after CNT==3. Writing CTRL=16'h8007 clears flag, unless it coincides with the next match (flag stays 1).
- Timer wrap, no reload: CNT=16'hFFFE, CMP=16'h0001, CTRL=1 → FFFE, FFFF, 0000, 0001, then match and flag=1, then 0002. A CNT write of 16'h0100 during run makes the next value 16'h0100.
- Reset mid-run: assert rst while the timer is running and gpio_out=8'hCD → all outputs and registers return to reset values immediately, no clock needed. RAM location 16'h0010 still reads its prior value after rst deasserts.
- Unmapped/X: read IO_BASE+7 and 16'h0000 of the region above the page → 0. A cycle with dmem_we=1'bx → no state change.
